// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin output multiplexer:
// the FSM encoding, the default sizes and the pointer wrap helper.
package mux_arb_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Advance a requester index by one, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set-bit search: starting at ptr and wrapping at N-1,
// returns whether any request is set and the index of the first one.
module rr_pick #(
    parameter int N = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [SW-1:0] cand_s;
    logic          hit_s;

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        found  = 1'b0;
        idx    = {SW{1'b0}};
        cand_s = {SW{1'b0}};
        hit_s  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_s = SW'((int'(ptr) + k) % N);
            hit_s  = req[cand_s];
            found  = found | hit_s;
            idx    = hit_s ? cand_s : idx;
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin N-to-1 word multiplexer: grants one requester, holds its
// captured word until downstream accepts it, then acks and rotates priority.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  sel,
    output logic [N-1:0]   ack
);

    logic [0:0]    state_r;
    logic [SW-1:0] ptr_r;
    logic          found_s;
    logic [SW-1:0] pick_idx_s;
    logic [W-1:0]  mux_data_s;
    logic [SW-1:0] next_ptr_s;
    logic [N-1:0]  ack_next_s;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    // N-to-1 steering of the picked requester's data slice.
    always_comb begin
        mux_data_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            mux_data_s = (pick_idx_s == SW'(i)) ? data_in[i*W +: W] : mux_data_s;
        end
    end

    // Post-handshake priority pointer and the one-hot ack for the granted slot.
    always_comb begin
        next_ptr_s = SW'(wrap_inc(int'(sel), N));
        ack_next_s = {{(N-1){1'b0}}, 1'b1} << sel;
    end

    // Grant/hold FSM; the word is captured at grant so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= {W{1'b0}};
            sel       <= {SW{1'b0}};
            ptr_r     <= {SW{1'b0}};
            ack       <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ack <= {N{1'b0}};
                    if (found_s) begin
                        sel       <= pick_idx_s;
                        out_data  <= mux_data_s;
                        out_valid <= 1'b1;
                        state_r   <= BUSY;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        ack       <= ack_next_s;
                        out_valid <= 1'b0;
                        ptr_r     <= next_ptr_s;
                        state_r   <= IDLE;
                    end else begin
                        ack <= {N{1'b0}};
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    ack       <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed scoreboard bench for mux_arbiter with N=4, W=8.
module tb_mux_arbiter;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  sel;
    logic [3:0]  ack;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] pend_ack = 4'b0000;

    mux_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted word against the scoreboard and check ack timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pend_ack = 4'b0000;
        end else begin
            check("ack", {28'd0, ack}, {28'd0, pend_ack});
            pend_ack = 4'b0000;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got sel=%0d data=%0h expected none", sel, out_data);
                end else begin
                    e = q.pop_front();
                    check("sb_sel", {30'd0, sel}, {30'd0, e.sel});
                    check("sb_data", {24'd0, out_data}, {24'd0, e.data});
                    pend_ack = 4'b0001 << e.sel;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 4'b0000; data_in = 32'h0; out_ready = 1'b0;
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Single requester 2
        data_in = 32'h44A52211; req = 4'b0100; out_ready = 1'b1;
        q.push_back('{2'd2, 8'hA5});
        tick();
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_sel", {30'd0, sel}, 32'd2);
        req = 4'b0000;
        tick();
        check("single_bubble", {31'd0, out_valid}, 32'd0);
        tick(); tick();

        // Wrap from ptr=3 with req=0011
        data_in = 32'h44332110; req = 4'b0011; out_ready = 1'b1;
        q.push_back('{2'd0, 8'h10});
        q.push_back('{2'd1, 8'h21});
        tick();
        check("wrap_first", {30'd0, sel}, 32'd0);
        tick(); tick();
        check("wrap_second", {30'd0, sel}, 32'd1);
        req = 4'b0000;
        tick(); tick();

        // Reset during BUSY discards the word
        data_in = 32'h77332211; req = 4'b1000; out_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_sel", {30'd0, sel}, 32'd3);
        tick();
        req = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_sel", {30'd0, sel}, 32'd0);
        check("mid_rst_ack", {28'd0, ack}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // All requesting: rotation 0,1,2,3,0 with one bubble between grants
        data_in = 32'h44332211; req = 4'b1111; out_ready = 1'b1;
        q.push_back('{2'd0, 8'h11});
        q.push_back('{2'd1, 8'h22});
        q.push_back('{2'd2, 8'h33});
        q.push_back('{2'd3, 8'h44});
        q.push_back('{2'd0, 8'h11});
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("rot_valid", {31'd0, out_valid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k == 9) req = 4'b0000;
        end
        tick();

        // Backpressure on requester 1 with data changing underneath
        data_in = 32'h44335A11; req = 4'b0010; out_ready = 1'b0;
        q.push_back('{2'd1, 8'h5A});
        tick();
        check("bp_sel", {30'd0, sel}, 32'd1);
        req = 4'b0000; data_in = 32'h44333C11;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_data", {24'd0, out_data}, 32'h5A);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_done", {31'd0, out_valid}, 32'd0);
        tick(); tick();

        // Request withdrawn after grant
        data_in = 32'h44962211; req = 4'b0100; out_ready = 1'b0;
        q.push_back('{2'd2, 8'h96});
        tick();
        req = 4'b0000;
        tick();
        out_ready = 1'b1;
        tick(); tick(); tick();

        check("sb_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
